ula_nibble_seq: RTL
===================

// Module: ula_nibble_seq
// PURPOSE
//  Time-multiplexed wide-word controller that sits around one 4-bit ula_74181 slice.
//  Upstream role: latches wide operands and presents them to the slice one nibble per cycle, LSB first.
//  Downstream role: collects each nibble result and chains the carry in time.
//  Output: a NIBBLES*4-bit result, carry-out and whole-word A=B flag.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices per word (>=2); word width W = 4*NIBBLES
// PORTS
//  clk         in   1    single clock, rising edge
//  rst         in   1    asynchronous reset, active-high
//  start       in   1    request: capture op_a/op_b/sel/mode/carry_in
//  op_a        in   W    operand A
//  op_b        in   W    operand B
//  sel         in   4    function select, passed to slice as s
//  mode        in   1    1 = logic, 0 = arithmetic, passed to slice as m
//  carry_in    in   1    Cn for nibble 0
//  busy        out  1    high while nibbles are being processed
//  done        out  1    one-cycle pulse: result/carry_out/a_eq_b_all valid
//  result      out  W    assembled F, held until next accepted start
//  carry_out   out  1    true carry out of MSB nibble
//  a_eq_b_all  out  1    AND of slice a_eq_b over all nibbles
//  alu_a       out  4    to slice a (current nibble of latched A)
//  alu_b       out  4    to slice b
//  alu_s       out  4    to slice s (latched sel)
//  alu_m       out  1    to slice m (latched mode)
//  alu_cin     out  1    to slice c_in
//  alu_f       in   4    from slice f
//  alu_cout    in   1    from slice c_out
//  alu_eq      in   1    from slice a_eq_b
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, done, carry_out, a_eq_b_all = 0; result = 0; index = 0.
//    All latched operand registers = 0.
//  - FSM states IDLE, RUN, DONE:
//    IDLE -(start)-> RUN; RUN -(index==NIBBLES-1)-> DONE; DONE -(start)-> RUN, else IDLE.
//  - start is sampled in IDLE and DONE only; start during RUN is ignored (no queueing).
//  - On accept: latch op_a, op_b, sel, mode; index=0; chain carry = carry_in; eq accumulator = 1.
//  - In RUN, alu_a/alu_b = latched nibble[index], alu_cin = chain carry.
//    Slice output is captured at the same cycle's clock edge:
//    result[4*index+:4] <= alu_f; eq accumulator &= alu_eq; index++.
//  - Carry correction: inv = (mode==0 && sel[3:2]==2'b10); true carry tc = alu_cout ^ inv.
//    Next chain carry = tc.
//    On the last nibble, carry_out <= tc, a_eq_b_all <= final accumulator.
//  - Logic mode: slice c_out is 0, so the chain carry is 0 after nibble 0 and carry_out = 0.
//  - The slice ignores Cn for sel 0000..0100 (m=0).
//    Result is then the concatenation of independent nibble results; this is not a wide-word op.
//  - Latency: start accepted at edge k -> busy high cycles k+1..k+NIBBLES; done high cycle k+NIBBLES+1.
//  - Back-to-back: start asserted while done=1 begins the next op with no idle cycle.
//  - Outside RUN, alu_a/alu_b/alu_cin = 0; alu_s/alu_m hold latched values.
//  - result, carry_out and a_eq_b_all update during RUN and are only valid while done=1 or after done.
//  - rst mid-RUN aborts immediately; no done pulse for the aborted op.
// CONFIGURATION
//  ULA_SEQ_ABORT_EN defined: adds input port abort (1 bit).
//    - abort=1 in RUN: next state IDLE; result, carry_out, a_eq_b_all cleared to 0; no done pulse.
//    - abort is ignored in IDLE/DONE; abort and start together in DONE: abort ignored, start accepted.
//  ULA_SEQ_ABORT_EN undefined: no abort port; RUN always completes NIBBLES cycles.
// TESTING (NIBBLES=4, bench instantiates ula_74181 on alu_* ports)
//  - Add (mode=0, sel=0101, cin=0): 0x1234+0x0FFF -> result=0x2233, carry_out=0.
//    busy for 4 cycles, done on 5th cycle after start.
//  - Add overflow: 0xFFFF+0x0001, sel=0101, cin=0 -> result=0x0000, carry_out=1, done pulse exactly 1 cycle.
//  - Subtract (sel=1000, cin=1): 0x1000-0x0001 -> result=0x0FFF, carry_out=1 (no borrow).
//    Check alu_cin sequence 1,0,0,0.
//  - Logic XOR (mode=1, sel=0110): 0xA5A5,0xFFFF -> result=0x5A5A, carry_out=0, a_eq_b_all=0.
//    With op_a=op_b=0x3C3C -> a_eq_b_all=1.
//  - Control: start pulsed during RUN -> ignored, result matches first op.
//    start held in DONE -> next op busy on the following cycle.
//  - Reset: rst asserted in 2nd RUN cycle -> busy, done, result, carry_out = 0 at once; no done afterward.
//    With ULA_SEQ_ABORT_EN, abort does the same via the synchronous path.

Source files
------------

// File: rtl/ula_nibble_seq.sv
// Nibble-serial wide-word sequencer around one 4-bit ula_74181 slice: LSB nibble first, carry chained in time.
// Optional abort input is enabled by defining ULA_SEQ_ABORT_EN.
module ula_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ULA_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic [3:0]           sel,
    input  logic                 mode,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 a_eq_b_all,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cin,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cout,
    input  logic                 alu_eq
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_r;
    logic [IW-1:0]  idx_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [3:0]     sel_r;
    logic           mode_r;
    logic           carry_r;
    logic           eq_r;
    logic [W-1:0]   result_r;
    logic           carry_out_r;
    logic           a_eq_b_all_r;
    logic           busy_r;
    logic           done_r;
    logic           inv_s;
    logic           tc_s;

    function automatic logic [3:0] nibble(input logic [W-1:0] word, input logic [IW-1:0] i);
        return word[{i, 2'b00} +: 4];
    endfunction

    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;
    assign carry_out  = carry_out_r;
    assign a_eq_b_all = a_eq_b_all_r;
    assign alu_s      = sel_r;
    assign alu_m      = mode_r;

    // The slice reports an inverted carry for the subtract-family selects; undo it here.
    assign inv_s = ~mode_r & (sel_r[3:2] == 2'b10);
    assign tc_s  = alu_cout ^ inv_s;

    // Present the current nibble and chain carry to the slice only while running.
    always_comb begin
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_cin = 1'b0;
        if (state_r == RUN) begin
            alu_a   = nibble(a_r, idx_r);
            alu_b   = nibble(b_r, idx_r);
            alu_cin = carry_r;
        end else begin
            alu_a   = 4'h0;
            alu_b   = 4'h0;
            alu_cin = 1'b0;
        end
    end

    // Sequencer FSM: accept, step through nibbles, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            a_r          <= '0;
            b_r          <= '0;
            sel_r        <= 4'h0;
            mode_r       <= 1'b0;
            carry_r      <= 1'b0;
            eq_r         <= 1'b0;
            result_r     <= '0;
            carry_out_r  <= 1'b0;
            a_eq_b_all_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= op_a;
                        b_r     <= op_b;
                        sel_r   <= sel;
                        mode_r  <= mode;
                        carry_r <= carry_in;
                        eq_r    <= 1'b1;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
`ifdef ULA_SEQ_ABORT_EN
                    if (abort) begin
                        result_r     <= '0;
                        carry_out_r  <= 1'b0;
                        a_eq_b_all_r <= 1'b0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b0;
                        idx_r        <= '0;
                        state_r      <= IDLE;
                    end else
`endif
                    begin
                        result_r[{idx_r, 2'b00} +: 4] <= alu_f;
                        eq_r    <= eq_r & alu_eq;
                        carry_r <= tc_s;
                        if (idx_r == LAST_IDX) begin
                            carry_out_r  <= tc_s;
                            a_eq_b_all_r <= eq_r & alu_eq;
                            idx_r        <= '0;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    idx_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
